sram22_req_ctrl: RTL and testbench



---
 rtl/sram22_req_ctrl.sv | 111 +++++++++++
 tb/tb_sram22_req_ctrl.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sram22_req_ctrl.sv
// sram22_req_ctrl: valid/ready request front-end for a single-port sram22
// macro. Drives the macro pins straight from the request port and collects
// the macro's registered read data into a credit-guarded response FIFO, so
// read data is never lost while the client holds off resp_ready.
module sram22_req_ctrl #(
  parameter int DATA_WIDTH  = 64,
  parameter int ADDR_WIDTH  = 11,
  parameter int WMASK_WIDTH = 8,
  parameter int RESP_DEPTH  = 3
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic                   req_we,
  input  logic [WMASK_WIDTH-1:0] req_wmask,
  input  logic [ADDR_WIDTH-1:0]  req_addr,
  input  logic [DATA_WIDTH-1:0]  req_wdata,
  output logic                   resp_valid,
  input  logic                   resp_ready,
  output logic [DATA_WIDTH-1:0]  resp_rdata,
  output logic                   sram_we,
  output logic [WMASK_WIDTH-1:0] sram_wmask,
  output logic [ADDR_WIDTH-1:0]  sram_addr,
  output logic [DATA_WIDTH-1:0]  sram_din,
  input  logic [DATA_WIDTH-1:0]  sram_dout
);

  localparam int OCC_W = $clog2(RESP_DEPTH + 1);
  localparam int PTR_W = (RESP_DEPTH > 1) ? $clog2(RESP_DEPTH) : 1;
  localparam logic [OCC_W-1:0] DEPTH_OCC = OCC_W'(RESP_DEPTH);
  localparam logic [OCC_W:0]   DEPTH_RES = (OCC_W + 1)'(RESP_DEPTH);
  localparam logic [PTR_W-1:0] LAST_PTR  = PTR_W'(RESP_DEPTH - 1);

  logic                  inflight_q, inflight_d;
  logic [OCC_W-1:0]      occ_q, occ_d;
  logic [PTR_W-1:0]      wptr_q, wptr_d;
  logic [PTR_W-1:0]      rptr_q, rptr_d;
  logic [DATA_WIDTH-1:0] fifo_q [RESP_DEPTH];

  logic [OCC_W:0] reserved;
  logic           fire;
  logic           rd_fire;
  logic           push;
  logic           pop;

  // Credits count both stored entries and the read whose data is still in
  // the macro's output register; only registered state feeds req_ready.
  assign reserved  = {1'b0, occ_q} + (OCC_W + 1)'(inflight_q);
  assign req_ready = !rst && (reserved < DEPTH_RES);

  assign fire    = req_valid && req_ready;
  assign rd_fire = fire && !req_we;

  // Non-fire cycles leave the macro doing a harmless dummy read.
  assign sram_addr  = req_addr;
  assign sram_din   = req_wdata;
  assign sram_wmask = req_wmask;
  assign sram_we    = fire && req_we;

  assign push       = inflight_q;
  assign resp_valid = !rst && (occ_q != '0);
  assign pop        = resp_valid && resp_ready;
  assign resp_rdata = fifo_q[rptr_q];

  // Next-state for the read pipeline flag, FIFO pointers and occupancy.
  always_comb begin
    inflight_d = rd_fire;
    wptr_d     = wptr_q;
    rptr_d     = rptr_q;
    occ_d      = occ_q;
    if (push) begin
      wptr_d = (wptr_q == LAST_PTR) ? '0 : wptr_q + PTR_W'(1);
    end
    if (pop) begin
      rptr_d = (rptr_q == LAST_PTR) ? '0 : rptr_q + PTR_W'(1);
    end
    case ({push, pop})
      2'b10:   occ_d = occ_q + OCC_W'(1);
      2'b01:   occ_d = occ_q - OCC_W'(1);
      default: occ_d = occ_q;
    endcase
  end

  // Control state register; reset drops any read still in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      inflight_q <= 1'b0;
      occ_q      <= '0;
      wptr_q     <= '0;
      rptr_q     <= '0;
    end else begin
      inflight_q <= inflight_d;
      occ_q      <= occ_d;
      wptr_q     <= wptr_d;
      rptr_q     <= rptr_d;
    end
  end

  // FIFO storage captures the macro's dout; contents are not reset.
  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_q[wptr_q] <= sram_dout;
    end
  end

  // Credits make a push into a full FIFO unreachable.
  overflow_chk: assert property (@(posedge clk) disable iff (rst)
    !(push && (occ_q == DEPTH_OCC)));

endmodule

// File: tb/tb_sram22_req_ctrl.sv
// Bench for sram22_req_ctrl: a behavioural sram22 macro plus a reference
// model of expected responses (queue of {data, cycle visible}).
module tb_sram22_req_ctrl;

  localparam int DW    = 64;
  localparam int AW    = 11;
  localparam int MW    = 8;
  localparam int DEPTH = 3;

  logic          clk = 1'b0;
  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [MW-1:0] req_wmask;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          resp_valid;
  logic          resp_ready;
  logic [DW-1:0] resp_rdata;
  logic          sram_we;
  logic [MW-1:0] sram_wmask;
  logic [AW-1:0] sram_addr;
  logic [DW-1:0] sram_din;
  logic [DW-1:0] sram_dout;

  sram22_req_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .WMASK_WIDTH(MW), .RESP_DEPTH(DEPTH)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_wmask(req_wmask), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_rdata(resp_rdata),
    .sram_we(sram_we), .sram_wmask(sram_wmask), .sram_addr(sram_addr),
    .sram_din(sram_din), .sram_dout(sram_dout)
  );

  always #5 clk = ~clk;

  // Behavioural macro: masked write and registered read every cycle.
  logic [DW-1:0] macro_mem [2**AW];
  always @(posedge clk) begin
    sram_dout <= macro_mem[sram_addr];
    if (sram_we) begin
      for (int b = 0; b < MW; b++)
        if (sram_wmask[b]) macro_mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
    end
  end

  typedef struct {
    logic [DW-1:0] d;
    int            t;
  } exp_t;

  logic [DW-1:0] ref_mem [2**AW];
  exp_t          expq [$];
  int            cyc;
  int            total;
  int            bad;
  logic          last_fire;
  logic          exp_ready;
  logic          exp_valid;
  exp_t          e;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: check outputs mid-cycle, advance the model, then move
  // to just after the next rising edge where new inputs get driven.
  task automatic tick();
    @(negedge clk);
    exp_ready = !rst && (expq.size() < DEPTH);
    exp_valid = !rst && (expq.size() > 0) && (expq[0].t <= cyc);
    chk("req_ready", {63'b0, req_ready}, {63'b0, exp_ready});
    chk("resp_valid", {63'b0, resp_valid}, {63'b0, exp_valid});
    if (exp_valid && resp_valid) chk("resp_rdata", resp_rdata, expq[0].d);
    chk("sram_we", {63'b0, sram_we}, {63'b0, req_valid && exp_ready && req_we});
    if (req_valid && exp_ready) chk("sram_addr", {53'b0, sram_addr}, {53'b0, req_addr});
    last_fire = req_valid && exp_ready;
    if (rst) begin
      expq.delete();
    end else begin
      if (exp_valid && resp_ready) void'(expq.pop_front());
      if (last_fire) begin
        if (req_we) begin
          for (int b = 0; b < MW; b++)
            if (req_wmask[b]) ref_mem[req_addr][b*8 +: 8] = req_wdata[b*8 +: 8];
        end else begin
          e.d = ref_mem[req_addr];
          e.t = cyc + 2;
          expq.push_back(e);
        end
      end
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic drive(input logic v, input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    req_valid = v;
    req_we    = we;
    req_wmask = m;
    req_addr  = a;
    req_wdata = d;
  endtask

  // Hold a request until accepted, bounded.
  task automatic issue(input logic we, input logic [MW-1:0] m,
                       input logic [AW-1:0] a, input logic [DW-1:0] d);
    int n;
    drive(1'b1, we, m, a, d);
    n = 0;
    do begin
      tick();
      n++;
    end while (!last_fire && n < 20);
    if (!last_fire) chk("issue_timeout", 64'(n), 64'(0));
    drive(1'b0, 1'b0, '0, '0, '0);
  endtask

  task automatic drain();
    int n;
    drive(1'b0, 1'b0, '0, '0, '0);
    resp_ready = 1'b1;
    n = 0;
    while (expq.size() > 0 && n < 40) begin
      tick();
      n++;
    end
    if (expq.size() > 0) chk("drain_timeout", 64'(expq.size()), 64'(0));
    tick();
  endtask

  int n_acc;

  initial begin
    total = 0;
    bad   = 0;
    cyc   = 0;
    for (int i = 0; i < 2**AW; i++) begin
      macro_mem[i] = '0;
      ref_mem[i]   = '0;
    end
    rst        = 1'b1;
    resp_ready = 1'b1;
    drive(1'b0, 1'b0, '0, '0, '0);
    @(posedge clk);
    #1;

    // Reset: nothing ready, nothing valid, writes blocked even if offered.
    drive(1'b1, 1'b1, 8'hFF, 11'h010, 64'hDEAD);
    repeat (3) tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    tick();

    // Write then read, full mask.
    issue(1'b1, 8'hFF, 11'h155, 64'h0123456789ABCDEF);
    issue(1'b0, 8'h00, 11'h155, '0);
    tick();
    chk("wr_rd_full", resp_rdata, 64'h0123456789ABCDEF);
    drain();

    // Partial mask, then no-op mask.
    issue(1'b1, 8'h81, 11'h000, 64'hFFFFFFFFFFFFFFFF);
    issue(1'b0, 8'h00, 11'h000, '0);
    tick();
    chk("partial_mask", resp_rdata, 64'hFF000000000000FF);
    drain();
    issue(1'b1, 8'h00, 11'h000, 64'h1234123412341234);
    issue(1'b0, 8'h00, 11'h000, '0);
    drain();

    // Streaming: preload addr*3, then 16 back-to-back reads.
    for (int i = 0; i < 16; i++) issue(1'b1, 8'hFF, AW'(i), 64'(i * 3));
    resp_ready = 1'b1;
    n_acc = 0;
    for (int i = 0; i < 16; i++) begin
      drive(1'b1, 1'b0, '0, AW'(i), '0);
      tick();
      if (last_fire) n_acc++;
    end
    chk("stream_accepted", 64'(n_acc), 64'd16);
    drain();

    // Backpressure: 5 reads offered with resp_ready low.
    resp_ready = 1'b0;
    n_acc = 0;
    for (int i = 0; i < 8; i++) begin
      drive(1'b1, 1'b0, '0, AW'(n_acc + 4), '0);
      tick();
      if (last_fire) n_acc++;
    end
    chk("bp_accepted", 64'(n_acc), 64'd3);
    resp_ready = 1'b1;
    for (int i = 0; i < 20 && n_acc < 5; i++) begin
      drive(1'b1, 1'b0, '0, AW'(n_acc + 4), '0);
      tick();
      if (last_fire) n_acc++;
    end
    chk("bp_all_accepted", 64'(n_acc), 64'd5);
    drain();

    // Reset with a read in flight: the response must never appear.
    issue(1'b0, 8'h00, 11'h155, '0);
    rst = 1'b1;
    drive(1'b1, 1'b1, 8'hFF, 11'h155, 64'hBAD);
    repeat (2) tick();
    rst = 1'b0;
    drive(1'b0, 1'b0, '0, '0, '0);
    repeat (4) tick();
    chk("post_rst_empty", {63'b0, resp_valid}, 64'd0);

    // Push/pop at DEPTH-1 with a read firing, across pointer wrap.
    resp_ready = 1'b0;
    for (int i = 0; i < 3; i++) issue(1'b0, 8'h00, AW'(i + 1), '0);
    resp_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 1'b0, '0, AW'(i + 7), '0);
      tick();
    end
    drain();

    // Random traffic over a small address window.
    for (int i = 0; i < 400; i++) begin
      drive($urandom_range(0, 9) < 7, $urandom_range(0, 9) < 4,
            MW'($urandom), AW'($urandom_range(0, 31)), {$urandom, $urandom});
      resp_ready = $urandom_range(0, 9) < 7;
      tick();
    end
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
